alu_ctrl_pipe: RTL

- Registered, handshaked successor to the combinational ALU controller.
- Decodes funct/ALUop into the ALU function code and jr flag, and presents them to the EX stage through one valid/ready pipeline register.
- Sequences multi-cycle multiply/divide operations with a cycle counter.
- Interlocks dependent HI/LO operations until the sequence completes.

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/md_sequencer.sv | 54 +++++
 rtl/alu_ctrl_pipe.sv | 73 +++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared funct/op constants and op classification helpers for the
// pipelined ALU controller.
package alu_ctrl_pkg;

  localparam int unsigned FN_JR    = 'h08;
  localparam int unsigned FN_MFHI  = 'h10;
  localparam int unsigned FN_MTHI  = 'h11;
  localparam int unsigned FN_MFLO  = 'h12;
  localparam int unsigned FN_MTLO  = 'h13;
  localparam int unsigned FN_MULT  = 'h18;
  localparam int unsigned FN_MULTU = 'h19;
  localparam int unsigned FN_DIV   = 'h1A;
  localparam int unsigned FN_DIVU  = 'h1B;
  localparam int unsigned FN_ADD   = 'h20;

  // Codes are passed zero-extended so wider function codes never alias.
  function automatic logic is_md(input int unsigned code);
    return code inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_div(input int unsigned code);
    return code inside {FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_hilo(input int unsigned code);
    return (code inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO}) || is_md(code);
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide busy sequencer: counts out a fixed number of busy cycles
// after each start pulse.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sel_div,
  output logic busy,
  output logic done
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter holds remaining busy cycles minus one; zero marks the last.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = sel_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end
      RUN: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = busy && (cnt == '0);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, valid/ready ALU controller with multiply/divide sequencing and
// HI/LO interlock.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_WIDTH    = 6,
  parameter int unsigned ALUOP_WIDTH    = 6,
  parameter int unsigned ALUFUNCT_WIDTH = 6,
  parameter int unsigned MULT_CYCLES    = 4,
  parameter int unsigned DIV_CYCLES     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [FUNCT_WIDTH-1:0]    funct,
  input  logic [ALUOP_WIDTH-1:0]    ALUop,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [ALUFUNCT_WIDTH-1:0] ALUfunct,
  output logic                      jr,
  output logic                      md_start,
  output logic                      md_busy,
  output logic                      md_done
);

  logic [ALUFUNCT_WIDTH-1:0] sel;
  logic                      jr_d;
  logic                      hazard;
  logic                      accept;
  logic                      handoff;

  always_comb begin
    sel  = (ALUop == '0) ? ALUFUNCT_WIDTH'(funct) : ALUFUNCT_WIDTH'(ALUop);
    jr_d = (ALUop == '0) && (32'(funct) == FN_JR);
  end

  // HI/LO consumers wait until a running or queued mult/div has completed.
  assign hazard   = id_valid && is_hilo(32'(sel)) &&
                    (md_busy || (ex_valid && is_md(32'(ALUfunct))));
  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = id_valid && id_ready;
  assign handoff  = ex_valid && ex_ready;
  assign md_start = handoff && is_md(32'(ALUfunct));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ALUfunct <= '0;
      jr       <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ALUfunct <= sel;
      jr       <= jr_d;
    end else if (handoff || flush) begin
      ex_valid <= 1'b0;
    end
  end

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start),
    .sel_div (is_div(32'(ALUfunct))),
    .busy    (md_busy),
    .done    (md_done)
  );

endmodule
